// File: rtl/crop_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// crop_sched : ROI request queue and start/done sequencer for crop stage.
// Optional macro CROP_SCHED_TIMEOUT_EN adds a START/BUSY watchdog.  Rev 1.0
// ==========================================================================
module crop_sched #(
  parameter int IN_ROWS        = 20,
  parameter int IN_COLS        = 20,
  parameter int OUT_ROWS       = 10,
  parameter int OUT_COLS       = 10,
  parameter int QDEPTH         = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         roi_tvalid,
  output logic                         roi_tready,
  input  logic [$clog2(IN_COLS)-1:0]   roi_x0,
  input  logic [$clog2(IN_ROWS)-1:0]   roi_y0,
  input  logic                         seq_ap_idle,
  output logic                         ap_start,
  input  logic                         ap_ready,
  input  logic                         ap_done,
  output logic [$clog2(IN_COLS)-1:0]   crop_x0,
  output logic [$clog2(IN_ROWS)-1:0]   crop_y0,
  output logic                         busy,
  output logic [$clog2(QDEPTH):0]      q_level,
  output logic [15:0]                  frame_cnt,
  output logic                         roi_err,
  output logic                         timeout
);

  localparam int c_XW = $clog2(IN_COLS);
  localparam int c_YW = $clog2(IN_ROWS);
  localparam int c_PW = $clog2(QDEPTH);
  localparam int c_LW = c_PW + 1;

  // Bounds are evaluated one bit wider than the coordinate so x0+width never wraps.
  localparam logic [c_XW:0]   c_OUT_COLS_X = OUT_COLS[c_XW:0];
  localparam logic [c_XW:0]   c_IN_COLS_X  = IN_COLS[c_XW:0];
  localparam logic [c_YW:0]   c_OUT_ROWS_Y = OUT_ROWS[c_YW:0];
  localparam logic [c_YW:0]   c_IN_ROWS_Y  = IN_ROWS[c_YW:0];
  localparam logic [c_LW-1:0] c_FULL       = QDEPTH[c_LW-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_BUSY  = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_XW-1:0] r_qx [QDEPTH];
  logic [c_YW-1:0] r_qy [QDEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic            r_busy;
  logic            r_ap_start;
  logic            r_roi_err;
  logic [c_XW-1:0] r_crop_x0;
  logic [c_YW-1:0] r_crop_y0;
  logic [15:0]     r_frame_cnt;

  logic [c_XW:0]   w_x_end;
  logic [c_YW:0]   w_y_end;
  logic            w_accept;
  logic            w_oob;
  logic            w_push;
  logic            w_pop;
  logic            w_wd_abort;

  assign roi_tready = (r_level != c_FULL);
  assign w_x_end    = {1'b0, roi_x0} + c_OUT_COLS_X;
  assign w_y_end    = {1'b0, roi_y0} + c_OUT_ROWS_Y;
  assign w_oob      = (w_x_end > c_IN_COLS_X) || (w_y_end > c_IN_ROWS_Y);
  assign w_accept   = roi_tvalid && roi_tready;
  assign w_push     = w_accept && !w_oob;
  assign w_pop      = (r_state == S_LOAD);

`ifdef CROP_SCHED_TIMEOUT_EN
  localparam int                c_WDW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WDW-1:0]  c_WD_LAST = c_WDW'(TIMEOUT_CYCLES - 1);

  logic [c_WDW-1:0] r_wd_cnt;
  logic             r_timeout;
  logic             w_wd_hit;

  assign w_wd_hit   = (r_wd_cnt == c_WD_LAST);
  // A done pulse arriving on the expiry cycle still completes the frame.
  assign w_wd_abort = w_wd_hit &&
                      ((r_state == S_START) || ((r_state == S_BUSY) && !ap_done));
  assign timeout    = r_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_wd_cnt <= '0;
      end else if (((r_state == S_START) || (r_state == S_BUSY)) && !w_wd_hit) begin
        r_wd_cnt <= r_wd_cnt + c_WDW'(1);
      end
      if (w_wd_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;

  assign w_wd_abort = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Queue storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qx[r_wr_ptr] <= roi_x0;
      r_qy[r_wr_ptr] <= roi_y0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_busy      <= 1'b0;
      r_ap_start  <= 1'b0;
      r_roi_err   <= 1'b0;
      r_crop_x0   <= '0;
      r_crop_y0   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_roi_err <= w_accept && w_oob;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase

      case (r_state)
        S_IDLE: begin
          if ((r_level != '0) && seq_ap_idle) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_crop_x0  <= r_qx[r_rd_ptr];
          r_crop_y0  <= r_qy[r_rd_ptr];
          r_ap_start <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_wd_abort) begin
            r_ap_start <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (ap_ready) begin
            r_ap_start <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ap_done) begin
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= S_IDLE;
          end else if (w_wd_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ap_start  = r_ap_start;
  assign busy      = r_busy;
  assign crop_x0   = r_crop_x0;
  assign crop_y0   = r_crop_y0;
  assign q_level   = r_level;
  assign frame_cnt = r_frame_cnt;
  assign roi_err   = r_roi_err;

endmodule

`default_nettype wire

// File: tb/tb_crop_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_crop_sched : directed stimulus, queue-based reference model, per-cycle
// compare of every output plus hand-computed literal checks.  Rev 1.0
// ==========================================================================
module tb_crop_sched;

  localparam int IN_ROWS        = 20;
  localparam int IN_COLS        = 20;
  localparam int OUT_ROWS       = 10;
  localparam int OUT_COLS       = 10;
  localparam int QDEPTH         = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int XW             = $clog2(IN_COLS);
  localparam int YW             = $clog2(IN_ROWS);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            roi_tvalid = 1'b0;
  logic            roi_tready;
  logic [XW-1:0]   roi_x0 = '0;
  logic [YW-1:0]   roi_y0 = '0;
  logic            seq_ap_idle = 1'b0;
  logic            ap_start;
  logic            ap_ready = 1'b0;
  logic            ap_done = 1'b0;
  logic [XW-1:0]   crop_x0;
  logic [YW-1:0]   crop_y0;
  logic            busy;
  logic [$clog2(QDEPTH):0] q_level;
  logic [15:0]     frame_cnt;
  logic            roi_err;
  logic            timeout;

  crop_sched #(
    .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS),
    .QDEPTH(QDEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .roi_tvalid(roi_tvalid), .roi_tready(roi_tready),
    .roi_x0(roi_x0), .roi_y0(roi_y0), .seq_ap_idle(seq_ap_idle), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .crop_x0(crop_x0), .crop_y0(crop_y0),
    .busy(busy), .q_level(q_level), .frame_cnt(frame_cnt), .roi_err(roi_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;
  int n_start_hi = 0;
  int n_err_pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is "in flight" from launch until done/abort;
  // m_age 0 is the pop cycle, afterwards start stays up until acknowledged.
  int m_qx[$];
  int m_qy[$];
  bit m_in_frame = 1'b0;
  bit m_acked    = 1'b0;
  bit m_err      = 1'b0;
  bit m_timeout  = 1'b0;
  bit m_acc;
  bit m_bad;
  int m_age    = 0;
  int m_wd     = 0;
  int m_crop_x = 0;
  int m_crop_y = 0;
  int m_frames = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_qx.delete();
      m_qy.delete();
      m_in_frame = 1'b0;
      m_acked    = 1'b0;
      m_err      = 1'b0;
      m_timeout  = 1'b0;
      m_age      = 0;
      m_wd       = 0;
      m_crop_x   = 0;
      m_crop_y   = 0;
      m_frames   = 0;
    end else begin
      m_acc = roi_tvalid && (m_qx.size() < QDEPTH);
      m_bad = m_acc && ((int'(roi_x0) + OUT_COLS > IN_COLS) ||
                        (int'(roi_y0) + OUT_ROWS > IN_ROWS));
      m_err = m_bad;
      if (!m_in_frame) begin
        if ((m_qx.size() > 0) && seq_ap_idle) begin
          m_in_frame = 1'b1;
          m_age      = 0;
          m_acked    = 1'b0;
          m_wd       = 0;
        end
      end else if (m_age == 0) begin
        m_crop_x = m_qx.pop_front();
        m_crop_y = m_qy.pop_front();
        m_age    = 1;
      end else begin
        m_wd++;
        if (m_acked && ap_done) begin
          m_in_frame = 1'b0;
          m_frames   = (m_frames + 1) % 65536;
        end
`ifdef CROP_SCHED_TIMEOUT_EN
        else if (m_wd >= TIMEOUT_CYCLES) begin
          m_in_frame = 1'b0;
          m_timeout  = 1'b1;
        end
`endif
        else if (!m_acked && ap_ready) begin
          m_acked = 1'b1;
        end
      end
      if (m_acc && !m_bad) begin
        m_qx.push_back(int'(roi_x0));
        m_qy.push_back(int'(roi_y0));
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("roi_tready", int'(roi_tready), int'(m_qx.size() != QDEPTH));
      check("q_level",    int'(q_level),    m_qx.size());
      check("ap_start",   int'(ap_start),   int'(m_in_frame && (m_age >= 1) && !m_acked));
      check("busy",       int'(busy),       int'(m_in_frame));
      check("crop_x0",    int'(crop_x0),    m_crop_x);
      check("crop_y0",    int'(crop_y0),    m_crop_y);
      check("frame_cnt",  int'(frame_cnt),  m_frames);
      check("roi_err",    int'(roi_err),    int'(m_err));
      check("timeout",    int'(timeout),    int'(m_timeout));
    end
    if (ap_start) n_start_hi++;
    if (roi_err)  n_err_pulses++;
  end

  task automatic push(input int x, input int y);
    @(negedge clk);
    roi_tvalid = 1'b1;
    roi_x0     = XW'(x);
    roi_y0     = YW'(y);
    @(negedge clk);
    roi_tvalid = 1'b0;
  endtask

  task automatic wait_start(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (ap_start) begin
        cycles = i;
        break;
      end
    end
    check("ap_start_seen", int'(ap_start), 1);
  endtask

  task automatic serve(input int bcycles);
    int lat;
    if (!ap_start) wait_start(lat);
    ap_ready = 1'b1;
    @(negedge clk);
    ap_ready = 1'b0;
    repeat (bcycles) @(negedge clk);
    ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",     int'(busy),      0);
    check("rst_ap_start", int'(ap_start),  0);
    check("rst_q_level",  int'(q_level),   0);
    check("rst_frames",   int'(frame_cnt), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", int'(roi_tready), 1);

    // Single frame (3,4): stray done in IDLE and START ignored, ready on 2nd START cycle.
    seq_ap_idle = 1'b1;
    ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
    n_start_hi = 0;
    push(3, 4);
    wait_start(lat);
    check("latency", lat, 2);
    ap_done = 1'b1;
    @(negedge clk);
    ap_done  = 1'b0;
    ap_ready = 1'b1;
    @(negedge clk);
    ap_ready = 1'b0;
    repeat (49) @(negedge clk);
    ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
    check("t1_crop_x0",   int'(crop_x0),   3);
    check("t1_crop_y0",   int'(crop_y0),   4);
    check("t1_start_len", n_start_hi,      2);
    check("t1_frames",    int'(frame_cnt), 1);

    // Fill the queue with the sequencer busy; fifth request must be refused.
    seq_ap_idle = 1'b0;
    push(0, 0);
    push(10, 10);
    push(1, 2);
    push(5, 5);
    check("full_level", int'(q_level),    4);
    check("full_ready", int'(roi_tready), 0);
    push(9, 9);
    check("full_level2", int'(q_level), 4);
    seq_ap_idle = 1'b1;
    repeat (4) serve(3);
    check("drain_frames", int'(frame_cnt), 5);
    check("drain_x0",     int'(crop_x0),   5);
    check("drain_y0",     int'(crop_y0),   5);
    check("drain_level",  int'(q_level),   0);

    // Push lands in the same cycle as the pop.
    seq_ap_idle = 1'b0;
    push(7, 8);
    @(negedge clk);
    seq_ap_idle = 1'b1;
    @(negedge clk);
    seq_ap_idle = 1'b0;
    roi_tvalid  = 1'b1;
    roi_x0      = XW'(4);
    roi_y0      = YW'(6);
    @(negedge clk);
    roi_tvalid = 1'b0;
    check("pp_level",  int'(q_level),  1);
    check("pp_start",  int'(ap_start), 1);
    check("pp_crop_x", int'(crop_x0),  7);
    check("pp_crop_y", int'(crop_y0),  8);
    serve(2);
    seq_ap_idle = 1'b1;
    serve(2);
    check("pp2_crop_x", int'(crop_x0),   4);
    check("pp2_crop_y", int'(crop_y0),   6);
    check("pp2_frames", int'(frame_cnt), 7);

    // Out-of-bounds requests, including one that would wrap in 5-bit arithmetic.
    n_err_pulses = 0;
    n_start_hi   = 0;
    push(11, 0);
    push(31, 0);
    push(0, 11);
    repeat (5) @(negedge clk);
    check("oob_pulses", n_err_pulses,    3);
    check("oob_level",  int'(q_level),   0);
    check("oob_starts", n_start_hi,      0);
    check("oob_frames", int'(frame_cnt), 7);

    // Reset in the middle of BUSY with a request still queued.
    push(2, 3);
    wait_start(lat);
    ap_ready = 1'b1;
    @(negedge clk);
    ap_ready    = 1'b0;
    seq_ap_idle = 1'b0;
    push(1, 1);
    repeat (5) @(negedge clk);
    check("mid_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("ar_busy",   int'(busy),       0);
    check("ar_start",  int'(ap_start),   0);
    check("ar_frames", int'(frame_cnt),  0);
    check("ar_level",  int'(q_level),    0);
    check("ar_x0",     int'(crop_x0),    0);
    check("ar_y0",     int'(crop_y0),    0);
    check("ar_ready",  int'(roi_tready), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_level",  int'(q_level),   0);
    check("post_rst_frames", int'(frame_cnt), 0);

`ifdef CROP_SCHED_TIMEOUT_EN
    // Never acknowledge the start; watchdog aborts and the next request still runs.
    seq_ap_idle = 1'b1;
    push(6, 7);
    wait_start(lat);
    repeat (110) @(negedge clk);
    check("wd_timeout", int'(timeout),   1);
    check("wd_busy",    int'(busy),      0);
    check("wd_frames",  int'(frame_cnt), 0);
    push(1, 2);
    serve(3);
    check("wd_next_frames", int'(frame_cnt), 1);
    check("wd_next_x0",     int'(crop_x0),   1);
    check("wd_next_y0",     int'(crop_y0),   2);
`endif

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crop_sched.md
CROP_SCHED -- requirements
Module: crop_sched

Interface
REQ-001 Parameter IN_ROWS, default 20, source image rows.
REQ-002 Parameter IN_COLS, default 20, source image columns.
REQ-003 Parameter OUT_ROWS, default 10, crop-box rows.
REQ-004 Parameter OUT_COLS, default 10, crop-box columns.
REQ-005 Parameter QDEPTH, default 4, ROI queue depth (power of two, >=2).
REQ-006 Parameter TIMEOUT_CYCLES, default 65535, watchdog limit (used only under CROP_SCHED_TIMEOUT_EN).
REQ-007 Port clk  input  1  single clock; all logic rising-edge.
REQ-008 Port reset  input  1  asynchronous, active-low reset.
REQ-009 Port roi_tvalid  input  1  ROI request valid.
REQ-010 Port roi_tready  output  1  ROI request accepted when high with roi_tvalid.
REQ-011 Port roi_x0  input  $clog2(IN_COLS)  requested crop left column.
REQ-012 Port roi_y0  input  $clog2(IN_ROWS)  requested crop top row.
REQ-013 Port seq_ap_idle  input  1  pixel sequencer idle, frame boundary.
REQ-014 Port ap_start  output  1  start to crop/normalize stage.
REQ-015 Port ap_ready  input  1  crop/normalize stage accepted start.
REQ-016 Port ap_done  input  1  crop/normalize stage finished frame (1-cycle pulse).
REQ-017 Port crop_x0  output  $clog2(IN_COLS)  active crop left column.
REQ-018 Port crop_y0  output  $clog2(IN_ROWS)  active crop top row.
REQ-019 Port busy  output  1  frame in flight.
REQ-020 Port q_level  output  $clog2(QDEPTH)+1  ROI entries queued.
REQ-021 Port frame_cnt  output  16  completed frames, wraps 65535->0.
REQ-022 Port roi_err  output  1  1-cycle pulse: out-of-bounds ROI dropped.
REQ-023 Port timeout  output  1  sticky watchdog flag.

Function
REQ-024 roi_tready SHALL equal (q_level != QDEPTH), from registered state only.
REQ-025 Handshake roi_tvalid&roi_tready with roi_x0+OUT_COLS>IN_COLS or roi_y0+OUT_ROWS>IN_ROWS SHALL not enqueue and SHALL pulse roi_err next cycle.
REQ-026 Bounds arithmetic SHALL be widened one bit beyond operand width; no wrap.
REQ-027 FSM states: IDLE, LOAD, START, BUSY.
REQ-028 IDLE->LOAD when q_level!=0 and seq_ap_idle=1; else hold.
REQ-029 LOAD: pop queue head into crop_x0/crop_y0 (1 cycle), ->START.
REQ-030 START: ap_start=1, held until cycle ap_ready=1 sampled, then ->BUSY with ap_start=0 next cycle.
REQ-031 BUSY: busy=1; on ap_done -> IDLE, frame_cnt+1 same edge.
REQ-032 ap_done outside BUSY SHALL be ignored.
REQ-033 crop_x0/crop_y0 SHALL change only in LOAD; stable through START and BUSY.
REQ-034 Simultaneous push (valid, in-bounds) and pop in LOAD SHALL both take effect; q_level unchanged.
REQ-035 Minimum latency queue-nonempty & seq_ap_idle -> ap_start high: 2 cycles.
REQ-036 busy SHALL be high in LOAD, START, BUSY.

Reset
REQ-037 reset low SHALL asynchronously force IDLE, empty queue, ap_start=0, busy=0, crop_x0=0, crop_y0=0, q_level=0, frame_cnt=0, roi_err=0, timeout=0; roi_tready=1 after release.
REQ-038 Reset mid-frame SHALL discard in-flight frame without incrementing frame_cnt.

Configuration
REQ-039 Macro CROP_SCHED_TIMEOUT_EN defined: cycle counter in START/BUSY; reaching TIMEOUT_CYCLES SHALL set timeout, drop ap_start, return to IDLE, frame_cnt unchanged.
REQ-040 Macro undefined: no counter; timeout tied 0; START/BUSY wait indefinitely.

Verification
REQ-041 Push (3,4), seq_ap_idle=1, ap_ready on 2nd START cycle, ap_done 50 cycles later -> crop_x0=3, crop_y0=4, ap_start high exactly 2 cycles, frame_cnt=1.
REQ-042 Push 5 in-bounds ROIs, seq_ap_idle=0 -> 4 accepted, roi_tready=0 on 5th, q_level=4.
REQ-043 Push (11,0) with defaults -> roi_err one pulse, q_level=0, no ap_start.
REQ-044 Reset low during BUSY -> all outputs to reset values immediately, frame_cnt=0, queue empty.
REQ-045 With CROP_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, no ap_done -> timeout=1 at cycle 100 of START/BUSY, state IDLE, next ROI still processed.
